asym_flush_fifo: RTL and testbench

ASYM_FLUSH_FIFO -- requirements
Module: asym_flush_fifo

---
 rtl/asym_flush_fifo.sv | 135 +++++++++++++
 tb/tb_asym_flush_fifo.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/asym_flush_fifo.sv
// Asymmetric FIFO: narrow write lanes are packed LSB-first into wide read words.
// A flush closes the open partial word so it becomes readable, then waits until
// every word up to and including it has been popped.
module asym_flush_fifo #(
    parameter int unsigned WR_W  = 4,
    parameter int unsigned RD_W  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_i,
    input  logic [WR_W-1:0]             wr_data_i,
    input  logic                        rd_i,
    output logic                        rd_valid_o,
    output logic [RD_W-1:0]             rd_data_o,
    output logic [$clog2(RD_W/WR_W):0]  rd_lanes_o,
    input  logic                        flush_req_i,
    output logic                        flush_done_o,
    output logic                        flush_busy_o,
    output logic [$clog2(DEPTH):0]      word_cnt_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic                        ovf_o,
    output logic                        unf_o
);

    localparam int unsigned RATIO = RD_W / WR_W;
    localparam int unsigned CW    = $clog2(RATIO);
    localparam int unsigned LW    = CW + 1;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = AW + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [RD_W-1:0] mem_q [DEPTH];
    logic [LW-1:0]   tag_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   target_q, target_d;
    logic [CW-1:0]   col_q, col_d;
    logic [0:0]      state_q, state_d;
    logic            done_q, done_d;
    logic            ovf_q, unf_q;

    logic            wr_ok, pop, flush_start, wrap, close, advance;
    logic [LW-1:0]   col_sum;
    logic [RD_W-1:0] head_word;
    logic [LW-1:0]   head_lanes;

    // Status flags and head-word selection; the word at wptr is always the open one.
    always_comb begin
        full_o       = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        rd_valid_o   = (wptr_q != rptr_q);
        word_cnt_o   = (wptr_q - rptr_q) + PW'(col_q != '0);
        empty_o      = (wptr_q == rptr_q) && (col_q == '0);
        flush_busy_o = (state_q == ST_FLUSH);
        flush_done_o = done_q;
        ovf_o        = ovf_q;
        unf_o        = unf_q;
        head_word    = mem_q[rptr_q[AW-1:0]];
        head_lanes   = tag_q[rptr_q[AW-1:0]];
        rd_lanes_o   = rd_valid_o ? head_lanes : '0;
    end

    // Zero-latency read data with lanes beyond the tagged count forced to zero.
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (rd_valid_o && (LW'(k) < head_lanes)) begin
                rd_data_o[k*WR_W +: WR_W] = head_word[k*WR_W +: WR_W];
            end
        end
    end

    // Next-state: packing, flush close of the open word, and flush completion.
    always_comb begin
        wr_ok       = wr_i && !full_o;
        pop         = rd_i && rd_valid_o;
        col_sum     = {1'b0, col_q} + LW'(wr_ok);
        wrap        = (col_sum == LW'(RATIO));
        flush_start = (state_q == ST_IDLE) && flush_req_i && !done_q;
        // Close includes a lane written in the same cycle as the request.
        close       = flush_start && (col_sum != '0) && !wrap;
        advance     = wrap || close;
        wptr_d      = wptr_q + PW'(advance);
        col_d       = advance ? '0 : col_sum[CW-1:0];
        rptr_d      = rptr_q + PW'(pop);
        target_d    = flush_start ? wptr_d : target_q;
        done_d      = (flush_start || (state_q == ST_FLUSH)) && (rptr_d == target_d);
        state_d     = state_q;
        if (done_d) begin
            state_d = ST_IDLE;
        end else if (flush_start) begin
            state_d = ST_FLUSH;
        end
    end

    // Pointer, control and sticky error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            target_q <= '0;
            col_q    <= '0;
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            target_q <= target_d;
            col_q    <= col_d;
            state_q  <= state_d;
            done_q   <= done_d;
            if (wr_i && full_o) ovf_q <= 1'b1;
            if (rd_i && !rd_valid_o) unf_q <= 1'b1;
        end
    end

    // Word storage and per-word lane tags; the tag tracks lanes written so far.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wptr_q[AW-1:0]][int'(col_q)*WR_W +: WR_W] <= wr_data_i;
            tag_q[wptr_q[AW-1:0]]                          <= col_sum;
        end
    end

endmodule

// File: tb/tb_asym_flush_fifo.sv
// Bench for asym_flush_fifo: directed scenarios plus random traffic, checked by a
// queue-based reference model and a scoreboard monitor sampling on the falling edge.
module tb_asym_flush_fifo;

    localparam int WR_W  = 4;
    localparam int RD_W  = 32;
    localparam int DEPTH = 4;
    localparam int RATIO = RD_W / WR_W;

    typedef struct {
        logic [31:0] data;
        int          lanes;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_i = 1'b0;
    logic [3:0]  wr_data_i = '0;
    logic        rd_i = 1'b0;
    logic        flush_req_i = 1'b0;
    logic        rd_valid_o;
    logic [31:0] rd_data_o;
    logic [3:0]  rd_lanes_o;
    logic        flush_done_o;
    logic        flush_busy_o;
    logic [2:0]  word_cnt_o;
    logic        empty_o, full_o, ovf_o, unf_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: closed words awaiting pop, plus the open partial word.
    word_t       mq[$];
    word_t       exp_q[$];
    logic [31:0] open_data  = '0;
    int          open_lanes = 0;
    bit          m_busy = 0, m_done = 0, m_ovf = 0, m_unf = 0;
    int          m_rem  = 0;
    bit          m_full, m_pop, m_fstart, m_was_busy, m_was_done;
    word_t       w_tmp;

    logic [31:0] arr [32];
    logic [31:0] exp_word;

    asym_flush_fifo #(.WR_W(WR_W), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_i         (wr_i),
        .wr_data_i    (wr_data_i),
        .rd_i         (rd_i),
        .rd_valid_o   (rd_valid_o),
        .rd_data_o    (rd_data_o),
        .rd_lanes_o   (rd_lanes_o),
        .flush_req_i  (flush_req_i),
        .flush_done_o (flush_done_o),
        .flush_busy_o (flush_busy_o),
        .word_cnt_o   (word_cnt_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .ovf_o        (ovf_o),
        .unf_o        (unf_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void close_word();
        w_tmp.data  = open_data;
        w_tmp.lanes = open_lanes;
        mq.push_back(w_tmp);
        exp_q.push_back(w_tmp);
        open_data  = '0;
        open_lanes = 0;
    endfunction

    // Reference model: applies the inputs of the ending cycle at each rising edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            exp_q.delete();
            open_data = '0; open_lanes = 0;
            m_busy = 0; m_done = 0; m_ovf = 0; m_unf = 0; m_rem = 0;
        end else begin
            m_full     = (mq.size() == DEPTH);
            m_was_busy = m_busy;
            m_was_done = m_done;
            m_pop      = rd_i && (mq.size() > 0);
            if (rd_i && !m_pop) m_unf = 1;
            if (m_pop) mq.delete(0);
            if (wr_i && m_full) begin
                m_ovf = 1;
            end else if (wr_i) begin
                open_data[open_lanes*WR_W +: WR_W] = wr_data_i;
                open_lanes++;
                if (open_lanes == RATIO) close_word();
            end
            m_fstart = !m_was_busy && flush_req_i && !m_was_done;
            if (m_fstart && open_lanes > 0) close_word();
            if (m_fstart) m_rem = mq.size();
            else if (m_was_busy && m_pop) m_rem--;
            m_done = (m_fstart || m_was_busy) && (m_rem == 0);
            m_busy = (m_fstart || m_was_busy) && !m_done;
        end
    end

    // Monitor: compares status against the model and pops the scoreboard on each read.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_rd_valid", rd_valid_o, 0);
            chk("rst_rd_data", rd_data_o, 0);
            chk("rst_empty", empty_o, 1);
            chk("rst_word_cnt", word_cnt_o, 0);
        end else begin
            chk("rd_valid", rd_valid_o, mq.size() > 0);
            chk("word_cnt", word_cnt_o, mq.size() + (open_lanes > 0 ? 1 : 0));
            chk("full", full_o, mq.size() == DEPTH);
            chk("empty", empty_o, mq.size() == 0 && open_lanes == 0);
            chk("ovf", ovf_o, m_ovf);
            chk("unf", unf_o, m_unf);
            chk("flush_done", flush_done_o, m_done);
            chk("flush_busy", flush_busy_o, m_busy);
            if (rd_i && rd_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    w_tmp = exp_q.pop_front();
                    chk("sb_data", rd_data_o, w_tmp.data);
                    chk("sb_lanes", rd_lanes_o, w_tmp.lanes);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_i = 0; rd_i = 0; flush_req_i = 0; wr_data_i = '0;
    endtask

    initial begin
        #2 rst = 1'b0;
        tick(); tick();
        chk("reset_empty", empty_o, 1);
        chk("reset_full", full_o, 0);
        rst = 1'b1;
        tick();

        // Eight lanes complete one word.
        for (int i = 1; i <= 8; i++) begin
            wr_i = 1; wr_data_i = 4'(i);
            tick();
        end
        idle_inputs();
        chk("t1_valid", rd_valid_o, 1);
        chk("t1_data", rd_data_o, 32'h8765_4321);
        chk("t1_lanes", rd_lanes_o, 8);
        rd_i = 1; tick(); idle_inputs();
        chk("t1_empty", empty_o, 1);

        // Flush closes a three-lane word; request arrives with the third lane.
        wr_i = 1; wr_data_i = 4'hA; tick();
        wr_data_i = 4'hB; tick();
        wr_data_i = 4'hC; flush_req_i = 1; tick();
        wr_i = 0;
        chk("t2_data", rd_data_o, 32'h0000_0CBA);
        chk("t2_lanes", rd_lanes_o, 3);
        chk("t2_busy", flush_busy_o, 1);
        rd_i = 1; tick();
        chk("t2_done", flush_done_o, 1);
        idle_inputs(); tick();
        chk("t2_done_pulse", flush_done_o, 0);

        // Lanes written after the request start the next word.
        wr_i = 1; wr_data_i = 4'h5; tick(); tick();
        flush_req_i = 1; tick();
        tick(); tick(); tick();
        wr_i = 0;
        chk("t3_lanes", rd_lanes_o, 3);
        chk("t3_data", rd_data_o, 32'h0000_0555);
        chk("t3_cnt", word_cnt_o, 2);
        rd_i = 1; tick();
        chk("t3_done", flush_done_o, 1);
        idle_inputs(); tick();
        flush_req_i = 1; tick();
        chk("t3_next_lanes", rd_lanes_o, 3);
        chk("t3_next_data", rd_data_o, 32'h0000_0555);
        rd_i = 1; tick();
        chk("t3_done2", flush_done_o, 1);
        idle_inputs(); tick();

        // Fill to full, overflow, then drain across the pointer wrap.
        for (int i = 0; i < 32; i++) begin
            wr_i = 1; wr_data_i = 4'($urandom); arr[i] = {28'd0, wr_data_i};
            tick();
        end
        wr_i = 0;
        chk("t4_full", full_o, 1);
        chk("t4_cnt", word_cnt_o, 4);
        wr_i = 1; wr_data_i = 4'hF; tick(); wr_i = 0;
        chk("t4_ovf", ovf_o, 1);
        chk("t4_cnt_after_ovf", word_cnt_o, 4);
        for (int w = 0; w < 4; w++) begin
            exp_word = '0;
            for (int k = 0; k < 8; k++) exp_word = exp_word | (arr[w*8+k] << (4*k));
            chk("t4_drain_data", rd_data_o, exp_word);
            rd_i = 1; tick(); rd_i = 0;
        end
        chk("t4_empty", empty_o, 1);

        // Underflow, then reset in the middle of a flush.
        rd_i = 1; tick(); rd_i = 0;
        chk("t5_unf", unf_o, 1);
        wr_i = 1; wr_data_i = 4'h7; tick(); tick();
        flush_req_i = 1; tick();
        idle_inputs();
        chk("t5_busy", flush_busy_o, 1);
        #3 rst = 1'b0;
        #1;
        chk("t5_rst_valid", rd_valid_o, 0);
        chk("t5_rst_data", rd_data_o, 0);
        chk("t5_rst_lanes", rd_lanes_o, 0);
        chk("t5_rst_done", flush_done_o, 0);
        chk("t5_rst_busy", flush_busy_o, 0);
        chk("t5_rst_cnt", word_cnt_o, 0);
        chk("t5_rst_empty", empty_o, 1);
        chk("t5_rst_full", full_o, 0);
        chk("t5_rst_ovf", ovf_o, 0);
        chk("t5_rst_unf", unf_o, 0);
        tick();
        rst = 1'b1;
        tick();

        // Random traffic: write-heavy, balanced, then read-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            if (i < 1000) begin
                wr_i = ($urandom_range(0, 3) != 0);
                rd_i = ($urandom_range(0, 3) == 0);
            end else if (i < 2000) begin
                wr_i = ($urandom_range(0, 1) != 0);
                rd_i = ($urandom_range(0, 1) != 0);
            end else begin
                wr_i = ($urandom_range(0, 3) == 0);
                rd_i = ($urandom_range(0, 3) != 0);
            end
            wr_data_i = 4'($urandom);
            if (flush_req_i && flush_done_o) flush_req_i = 0;
            else if (!flush_req_i && $urandom_range(0, 29) == 0) flush_req_i = 1;
            tick();
        end
        idle_inputs();
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
